// File: rtl/mem_arb_pkg.sv
// Shared types for the instruction/data memory-port arbiter: FSM states,
// grant identifiers and default bus widths.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    INST = 2'd2
  } state_e;

  typedef enum logic {
    GNT_DATA = 1'b0,
    GNT_INST = 1'b1
  } gnt_e;

  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;

endpackage

// File: rtl/mem_port_arbiter.sv
// Shares one fixed-latency memory between the fetch port and the data port,
// alternating grants under contention and stalling the pipeline meanwhile.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int MEM_LAT = 4,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic [DATA_W-1:0] if_rdata_o,
  output logic              if_ack_o,
  input  logic              dm_req_i,
  input  logic              dm_we_i,
  input  logic [ADDR_W-1:0] dm_addr_i,
  input  logic [DATA_W-1:0] dm_wdata_i,
  output logic [DATA_W-1:0] dm_rdata_o,
  output logic              dm_ack_o,
  output logic              stall_o,
  output logic              mem_en_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i
);

  localparam int              CNT_W    = $clog2(MEM_LAT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_LAT - 1);

  state_e            state_q, state_d;
  gnt_e              last_gnt_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [ADDR_W-1:0] addr_q;
  logic              we_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] if_rdata_q, dm_rdata_q;
  logic              if_ack_q, dm_ack_q;
  logic              if_req_m, dm_req_m;
  logic              grant_data;
  logic              access_done;

  // A requester being acked this cycle still holds its request; mask it so
  // the ack cycle can hand the memory to the other port.
  assign if_req_m    = if_req_i & ~if_ack_q;
  assign dm_req_m    = dm_req_i & ~dm_ack_q;
  assign grant_data  = dm_req_m & (~if_req_m | (last_gnt_q == GNT_INST));
  assign access_done = (state_q != IDLE) && (cnt_q == CNT_LAST);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (grant_data)    state_d = DATA;
        else if (if_req_m) state_d = INST;
      end
      DATA, INST: begin
        if (access_done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mem_en_o = 1'b0;
    mem_we_o = 1'b0;
    case (state_q)
      DATA: begin
        mem_en_o = 1'b1;
        mem_we_o = we_q;
      end
      INST: mem_en_o = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q      <= '0;
      last_gnt_q <= GNT_INST;
      addr_q     <= '0;
      we_q       <= 1'b0;
      wdata_q    <= '0;
      if_rdata_q <= '0;
      dm_rdata_q <= '0;
      if_ack_q   <= 1'b0;
      dm_ack_q   <= 1'b0;
    end else begin
      if_ack_q <= (state_q == INST) && access_done;
      dm_ack_q <= (state_q == DATA) && access_done;
      if (state_q == IDLE) begin
        cnt_q <= '0;
        if (grant_data) begin
          last_gnt_q <= GNT_DATA;
          addr_q     <= dm_addr_i;
          we_q       <= dm_we_i;
          wdata_q    <= dm_wdata_i;
        end else if (if_req_m) begin
          last_gnt_q <= GNT_INST;
          addr_q     <= if_addr_i;
          we_q       <= 1'b0;
        end
      end else begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
      // Read data is only valid on the final access cycle.
      if (access_done && (state_q == INST))         if_rdata_q <= mem_rdata_i;
      if (access_done && (state_q == DATA) && !we_q) dm_rdata_q <= mem_rdata_i;
    end
  end

  assign if_rdata_o  = if_rdata_q;
  assign dm_rdata_o  = dm_rdata_q;
  assign if_ack_o    = if_ack_q;
  assign dm_ack_o    = dm_ack_q;
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;
  assign stall_o     = rst_n_i & ((if_req_i & ~if_ack_q) | (dm_req_i & ~dm_ack_q));

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: MEM_LAT=4 instance for the main
// scenarios and a MEM_LAT=1 instance for the single-cycle access case.
module tb_mem_port_arbiter;

  logic        clk;
  logic        rst_n;

  logic        if_req, dm_req, dm_we;
  logic [31:0] if_addr, dm_addr, dm_wdata, mem_rdata;
  logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata;
  logic        if_ack, dm_ack, stall, mem_en, mem_we;

  logic        if_req1, dm_req1, dm_we1;
  logic [31:0] if_addr1, dm_addr1, dm_wdata1, mem_rdata1;
  logic [31:0] if_rdata1, dm_rdata1, mem_addr1, mem_wdata1;
  logic        if_ack1, dm_ack1, stall1, mem_en1, mem_we1;

  int checks = 0;
  int errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  mem_port_arbiter #(.MEM_LAT(4), .ADDR_W(32), .DATA_W(32)) u_dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .if_req_i(if_req), .if_addr_i(if_addr), .if_rdata_o(if_rdata), .if_ack_o(if_ack),
    .dm_req_i(dm_req), .dm_we_i(dm_we), .dm_addr_i(dm_addr), .dm_wdata_i(dm_wdata),
    .dm_rdata_o(dm_rdata), .dm_ack_o(dm_ack), .stall_o(stall),
    .mem_en_o(mem_en), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
    .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata)
  );

  mem_port_arbiter #(.MEM_LAT(1), .ADDR_W(32), .DATA_W(32)) u_dut1 (
    .clk_i(clk), .rst_n_i(rst_n),
    .if_req_i(if_req1), .if_addr_i(if_addr1), .if_rdata_o(if_rdata1), .if_ack_o(if_ack1),
    .dm_req_i(dm_req1), .dm_we_i(dm_we1), .dm_addr_i(dm_addr1), .dm_wdata_i(dm_wdata1),
    .dm_rdata_o(dm_rdata1), .dm_ack_o(dm_ack1), .stall_o(stall1),
    .mem_en_o(mem_en1), .mem_we_o(mem_we1), .mem_addr_o(mem_addr1),
    .mem_wdata_o(mem_wdata1), .mem_rdata_i(mem_rdata1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge; that starts a new cycle.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    if_req = 0; dm_req = 0; dm_we = 0;
    if_addr = 0; dm_addr = 0; dm_wdata = 0; mem_rdata = 0;
    if_req1 = 0; dm_req1 = 0; dm_we1 = 0;
    if_addr1 = 0; dm_addr1 = 0; dm_wdata1 = 0; mem_rdata1 = 0;

    // Reset state
    #2;
    chk("rst_en", mem_en, 0);
    chk("rst_we", mem_we, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_if_ack", if_ack, 0);
    chk("rst_dm_ack", dm_ack, 0);
    chk("rst_if_rdata", if_rdata, 0);
    chk("rst_dm_rdata", dm_rdata, 0);
    chk("rst_stall", stall, 0);
    chk("rst1_en", mem_en1, 0);
    cyc();
    cyc();
    rst_n = 1'b1;

    // Fetch read
    cyc();
    if_req = 1; if_addr = 32'h40; mem_rdata = 32'hFFFF_FFFF;
    #1;
    chk("f0_stall", stall, 1);
    chk("f0_en", mem_en, 0);
    for (int c = 1; c <= 4; c++) begin
      cyc();
      mem_rdata = (c == 4) ? 32'h1234_5678 : 32'hFFFF_FFFF;
      #1;
      chk("f_acc_en", mem_en, 1);
      chk("f_acc_addr", mem_addr, 32'h40);
      chk("f_acc_we", mem_we, 0);
      chk("f_acc_stall", stall, 1);
      chk("f_acc_ack", if_ack, 0);
    end
    cyc();
    mem_rdata = 32'hFFFF_FFFF;
    #1;
    chk("f5_ack", if_ack, 1);
    chk("f5_rdata", if_rdata, 32'h1234_5678);
    chk("f5_stall", stall, 0);
    chk("f5_en", mem_en, 0);
    cyc();
    if_req = 0;
    #1;
    chk("f6_ack", if_ack, 0);
    chk("f6_en", mem_en, 0);

    // Tie: data wins the first tie after a fetch grant
    cyc();
    if_req = 1; if_addr = 32'h44;
    dm_req = 1; dm_we = 0; dm_addr = 32'h200;
    #1;
    chk("t0_stall", stall, 1);
    for (int c = 1; c <= 4; c++) begin
      cyc();
      mem_rdata = (c == 4) ? 32'hCAFE_F00D : 32'hFFFF_FFFF;
      #1;
      chk("t_d_en", mem_en, 1);
      chk("t_d_addr", mem_addr, 32'h200);
      chk("t_d_we", mem_we, 0);
    end
    cyc();
    mem_rdata = 32'hFFFF_FFFF;
    #1;
    chk("t5_dm_ack", dm_ack, 1);
    chk("t5_dm_rdata", dm_rdata, 32'hCAFE_F00D);
    chk("t5_if_ack", if_ack, 0);
    chk("t5_stall", stall, 1);
    chk("t5_en", mem_en, 0);
    dm_req = 0;
    for (int c = 6; c <= 9; c++) begin
      cyc();
      mem_rdata = (c == 9) ? 32'h0BAD_C0DE : 32'hFFFF_FFFF;
      #1;
      chk("t_i_en", mem_en, 1);
      chk("t_i_addr", mem_addr, 32'h44);
      chk("t_i_dm_ack", dm_ack, 0);
    end
    cyc();
    mem_rdata = 32'hFFFF_FFFF;
    #1;
    chk("t10_if_ack", if_ack, 1);
    chk("t10_if_rdata", if_rdata, 32'h0BAD_C0DE);
    chk("t10_dm_ack", dm_ack, 0);
    if_req = 0;

    // Contention: both ports request continuously for four accesses
    cyc();
    dm_req = 1; dm_we = 0; dm_addr = 32'h300;
    if_req = 1; if_addr = 32'h80;
    for (int k = 0; k < 4; k++) begin
      for (int c = 1; c <= 5; c++) begin
        cyc();
        mem_rdata = (c == 4) ? (32'h1111_0000 + 32'(k)) : 32'hFFFF_FFFF;
        if (c == 5 && k == 3) begin
          dm_req = 0;
          if_req = 0;
        end
        #1;
        if (c == 1) chk("c_addr", mem_addr, (k % 2 == 0) ? 32'h300 : 32'h80);
        if (c == 5) begin
          chk("c_dm_ack", dm_ack, (k % 2 == 0) ? 32'd1 : 32'd0);
          chk("c_if_ack", if_ack, (k % 2 == 1) ? 32'd1 : 32'd0);
          if (k % 2 == 0) chk("c_dm_rdata", dm_rdata, 32'h1111_0000 + 32'(k));
          else            chk("c_if_rdata", if_rdata, 32'h1111_0000 + 32'(k));
        end
      end
    end
    cyc();
    #1;
    chk("c_end_en", mem_en, 0);

    // Write, with requester inputs changing mid-access
    cyc();
    dm_req = 1; dm_we = 1; dm_addr = 32'h100; dm_wdata = 32'hDEAD_BEEF;
    #1;
    for (int c = 1; c <= 4; c++) begin
      cyc();
      mem_rdata = (c == 4) ? 32'h5555_5555 : 32'hFFFF_FFFF;
      if (c == 2) begin
        dm_we = 0; dm_addr = 32'h1FC; dm_wdata = 32'h0;
      end
      #1;
      chk("w_en", mem_en, 1);
      chk("w_we", mem_we, 1);
      chk("w_addr", mem_addr, 32'h100);
      chk("w_wdata", mem_wdata, 32'hDEAD_BEEF);
    end
    cyc();
    #1;
    chk("w5_ack", dm_ack, 1);
    chk("w5_rdata_held", dm_rdata, 32'h1111_0002);
    chk("w5_we", mem_we, 0);
    dm_req = 0;

    // Reset in cycle 2 of a data read
    cyc();
    dm_req = 1; dm_we = 0; dm_addr = 32'h400; mem_rdata = 32'hFFFF_FFFF;
    #1;
    cyc();
    #1;
    chk("r1_en", mem_en, 1);
    cyc();
    rst_n = 0;
    #1;
    chk("r2_en", mem_en, 0);
    chk("r2_we", mem_we, 0);
    chk("r2_addr", mem_addr, 0);
    chk("r2_wdata", mem_wdata, 0);
    chk("r2_stall", stall, 0);
    chk("r2_dm_ack", dm_ack, 0);
    chk("r2_dm_rdata", dm_rdata, 0);
    chk("r2_if_rdata", if_rdata, 0);
    cyc();
    rst_n = 1;
    #1;
    chk("r3_dm_ack", dm_ack, 0);
    chk("r3_en", mem_en, 0);
    for (int c = 1; c <= 4; c++) begin
      cyc();
      mem_rdata = (c == 4) ? 32'hA1B2_C3D4 : 32'hFFFF_FFFF;
      #1;
      chk("r_acc_en", mem_en, 1);
      chk("r_acc_addr", mem_addr, 32'h400);
      chk("r_acc_ack", dm_ack, 0);
    end
    cyc();
    #1;
    chk("r_ack", dm_ack, 1);
    chk("r_rdata", dm_rdata, 32'hA1B2_C3D4);
    dm_req = 0;

    // MEM_LAT=1 with the fetch address changing during the access
    cyc();
    if_req1 = 1; if_addr1 = 32'h10;
    #1;
    chk("l1_0_en", mem_en1, 0);
    cyc();
    if_addr1 = 32'h20; mem_rdata1 = 32'h77;
    #1;
    chk("l1_1_en", mem_en1, 1);
    chk("l1_1_addr", mem_addr1, 32'h10);
    chk("l1_1_ack", if_ack1, 0);
    cyc();
    mem_rdata1 = 32'h0;
    #1;
    chk("l1_2_ack", if_ack1, 1);
    chk("l1_2_rdata", if_rdata1, 32'h77);
    chk("l1_2_en", mem_en1, 0);
    if_req1 = 0;
    cyc();
    #1;
    chk("l1_3_ack", if_ack1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
